neopixel_frame_sequencer: RTL and testbench
===========================================

# neopixel_frame_sequencer

Frame-level controller for the WS2812 (NeoPixel) LED chain.
- On request, it walks the LED index from 0 to NUM_LEDS-1 and fetches one 24-bit GRB word per LED from a pixel source (game renderer or framebuffer).
- It serialises each word MSB-first onto the single-wire data line using programmable high/low cycle counts.
- After the last LED it holds the line low for the latch/reset interval, then signals frame completion.
- It replaces ad-hoc bit/LED counting inside game top levels with one reusable sequencer.

## Interface
Parameters:
- NUM_LEDS, 64: LEDs in the chain. Must be ≥1.
- TBIT, 63: clk cycles per data bit (1.25 µs at 50 MHz).
- T0H, 20: high cycles for a 0 bit. Requires 0 < T0H < T1H < TBIT.
- T1H, 40: high cycles for a 1 bit.
- RESET_CYCLES, 3000: low cycles for the latch interval (≥50 µs).

Ports:
- clk, in, 1: single clock, rising edge.
- rst, in, 1: asynchronous, active-high reset.
- frame_req, in, 1: level request to send one frame.
- busy, out, 1: high from the cycle after acceptance until the cycle after frame_done.
- frame_done, out, 1: one-cycle pulse at the end of the latch interval.
- pix_rd, out, 1: one-cycle read strobe.
- pix_addr, out, $clog2(NUM_LEDS) (min 1): LED index to read.
- pix_data, in, 24: GRB word, valid the cycle after pix_rd.
- dout, out, 1: serial data to the LED chain.

## Operation
Reset values: state IDLE; dout=0, busy=0, frame_done=0, pix_rd=0, pix_addr=0; all counters 0.

FSM states:
- IDLE: dout=0. If frame_req=1 at an edge, go to FETCH and clear the LED index.
- FETCH: pix_rd=1 and pix_addr=index for exactly one cycle, then go to LOAD.
- LOAD: capture pix_data into a 24-bit shift register, set bit counter=23 and cycle counter=0, then go to SHIFT.
- SHIFT:
  - dout=1 while cycle counter < (shreg[23] ? T1H : T0H); otherwise dout=0.
  - When cycle counter = TBIT-1: shift left by 1 and decrement the bit counter.
  - After bit 0 completes: if index = NUM_LEDS-1 go to LATCH, else increment the index and go to FETCH.
- LATCH: dout=0 for RESET_CYCLES cycles. On the final cycle, go to IDLE with frame_done=1 for one cycle.

Rules:
- Inter-LED gap: FETCH and LOAD add exactly 2 low cycles after the last bit of each LED except the final one. WS2812 low-time tolerance covers this.
- frame_req is ignored outside IDLE; no queuing. If it is still high when IDLE is re-entered, a new frame starts immediately (back-to-back frames).
- pix_data is sampled only in LOAD; other cycles are don't-care.
- Counter widths: cycle counter $clog2(TBIT), bit counter 5, latch counter $clog2(RESET_CYCLES+1). No wrap occurs within legal parameters.
- Asserting rst mid-frame forces dout=0 and IDLE immediately. The partial frame is abandoned; the chain recovers on the next full frame after a latch.

## Timing
- frame_req sampled at edge E: FETCH in cycle E+1 (pix_rd=1, busy=1), LOAD in E+2, first dout rise in E+3.
- Bit period is exactly TBIT cycles; the high phase is T0H or T1H cycles starting at the bit's first cycle.
- LED-to-LED pitch is 24·TBIT+2 cycles.
- Total frame length from the first FETCH cycle to the frame_done cycle inclusive is NUM_LEDS·(24·TBIT+2)+RESET_CYCLES cycles.
- frame_done and the return to IDLE occur on the same edge; busy is low in the following cycle.
- All outputs are registered; no combinational path from inputs to outputs.

## Structure
- Shared package `neopixel_pkg`: the FSM state enum (IDLE, FETCH, LOAD, SHIFT, LATCH), a 24-bit GRB type, and default timing constants for 50 MHz.
- One sub-module, `neopixel_bit_tx`:
  - inputs: load strobe, 24-bit word;
  - outputs: dout and a word-done pulse;
  - owns the cycle counter, bit counter and shift register.
- The top holds the FSM, LED index, latch counter and read port.

## Test plan
Test parameters: NUM_LEDS=2, TBIT=10, T0H=3, T1H=7, RESET_CYCLES=20.

1. Reset, then pulse frame_req for 1 cycle with data 24'h800001 at both addresses → dout high 7, low 3, then 22 bits of high 3/low 7, then the last bit high 7/low 3. pix_addr 0 then 1. frame_done pulses at cycle 2·242+20=504 after the first FETCH.
2. frame_req held high → second frame's pix_rd occurs 1 cycle after frame_done; busy low for exactly 1 cycle between frames.
3. frame_req toggled during SHIFT/LATCH → no effect; exactly one frame, one frame_done.
4. rst asserted mid-SHIFT (dout high) → dout=0, busy=0, pix_rd=0 asynchronously. A new request restarts at pix_addr=0.
5. All-zero data → every bit high exactly 3 cycles. All-ones data (24'hFFFFFF) → every bit high exactly 7 cycles. Gap between LED 0's last bit and LED 1's first rise is 3+2 low cycles for all-ones.
6. NUM_LEDS=1 → single FETCH at pix_addr=0, LATCH directly after 24 bits, frame_done at cycle 262.

Source files
------------

// File: rtl/neopixel_pkg.sv
// Shared types and default 50 MHz timing for the WS2812 frame sequencer.
package neopixel_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LOAD,
    SHIFT,
    LATCH
  } state_t;

  typedef logic [23:0] grb_t;

  localparam int unsigned DEF_NUM_LEDS     = 64;
  localparam int unsigned DEF_TBIT         = 63;
  localparam int unsigned DEF_T0H          = 20;
  localparam int unsigned DEF_T1H          = 40;
  localparam int unsigned DEF_RESET_CYCLES = 3000;

  // LED index width, never narrower than one bit
  function automatic int unsigned addr_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/neopixel_frame_sequencer_if.sv
// Frame request / pixel read / serial output bundle of the sequencer.
interface neopixel_frame_sequencer_if
  import neopixel_pkg::*;
#(
  parameter int unsigned NUM_LEDS = DEF_NUM_LEDS
) ();
  localparam int unsigned AW = addr_width(NUM_LEDS);

  logic          frame_req;
  logic          busy;
  logic          frame_done;
  logic          pix_rd;
  logic [AW-1:0] pix_addr;
  grb_t          pix_data;
  logic          dout;

  // Sequencer side
  modport master (
    input  frame_req, pix_data,
    output busy, frame_done, pix_rd, pix_addr, dout
  );

  // Host / pixel source side
  modport slave (
    output frame_req, pix_data,
    input  busy, frame_done, pix_rd, pix_addr, dout
  );
endinterface

// File: rtl/neopixel_bit_tx.sv
// Serialises one 24-bit GRB word MSB-first with WS2812 high/low timing.
module neopixel_bit_tx
  import neopixel_pkg::*;
#(
  parameter int unsigned TBIT = DEF_TBIT,
  parameter int unsigned T0H  = DEF_T0H,
  parameter int unsigned T1H  = DEF_T1H
) (
  input  logic clk,
  input  logic rst,
  input  logic i_load,
  input  grb_t i_word,
  output logic o_dout,
  output logic o_word_done
);
  localparam int unsigned   CW      = $clog2(TBIT);
  localparam logic [CW-1:0] LP_LAST = CW'(TBIT - 1);
  localparam logic [CW-1:0] LP_T0H  = CW'(T0H);
  localparam logic [CW-1:0] LP_T1H  = CW'(T1H);

  logic [CW-1:0] r_cnt;
  logic [4:0]    r_bit;
  grb_t          r_shreg;
  logic          r_active;
  logic          r_dout;

  logic          w_bit_end;
  logic [CW-1:0] w_cnt_nxt;
  logic [CW-1:0] w_high;

  assign w_bit_end   = r_active && (r_cnt == LP_LAST);
  assign w_cnt_nxt   = r_cnt + 1'b1;
  assign w_high      = r_shreg[23] ? LP_T1H : LP_T0H;
  // Flags the final cycle of bit 0 so the FSM leaves SHIFT on that same edge
  assign o_word_done = w_bit_end && (r_bit == '0);
  assign o_dout      = r_dout;

  // Bit/cycle counting; dout is registered from the next cycle's count so
  // every bit starts high on its first cycle (T0H is always non-zero)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_shreg  <= '0;
      r_bit    <= '0;
      r_cnt    <= '0;
      r_active <= 1'b0;
      r_dout   <= 1'b0;
    end else if (i_load) begin
      r_shreg  <= i_word;
      r_bit    <= 5'd23;
      r_cnt    <= '0;
      r_active <= 1'b1;
      r_dout   <= 1'b1;
    end else if (w_bit_end) begin
      r_shreg  <= {r_shreg[22:0], 1'b0};
      r_cnt    <= '0;
      r_active <= (r_bit != '0);
      r_dout   <= (r_bit != '0);
      if (r_bit != '0) r_bit <= r_bit - 1'b1;
    end else if (r_active) begin
      r_cnt  <= w_cnt_nxt;
      r_dout <= (w_cnt_nxt < w_high);
    end
  end
endmodule

// File: rtl/neopixel_frame_sequencer.sv
// WS2812 frame sequencer: fetches one GRB word per LED, serialises it, then latches.
module neopixel_frame_sequencer
  import neopixel_pkg::*;
#(
  parameter int unsigned NUM_LEDS     = DEF_NUM_LEDS,
  parameter int unsigned TBIT         = DEF_TBIT,
  parameter int unsigned T0H          = DEF_T0H,
  parameter int unsigned T1H          = DEF_T1H,
  parameter int unsigned RESET_CYCLES = DEF_RESET_CYCLES
) (
  input  logic                        clk,
  input  logic                        rst,
  neopixel_frame_sequencer_if.master  bus
);
  localparam int unsigned   AW          = addr_width(NUM_LEDS);
  localparam int unsigned   LW          = $clog2(RESET_CYCLES + 1);
  localparam logic [AW-1:0] LP_IDX_LAST = AW'(NUM_LEDS - 1);
  // LATCH lasts RESET_CYCLES-1 cycles; the frame_done cycle (already IDLE,
  // line still low) completes the latch interval
  localparam logic [LW-1:0] LP_LAT_LAST = LW'(RESET_CYCLES - 2);

  state_t        r_state, w_next;
  logic [AW-1:0] r_idx;
  logic [LW-1:0] r_lat;
  logic          r_busy, r_done, r_pix_rd;
  logic          w_busy_d, w_done_d, w_rd_d;
  logic          w_load, w_word_done, w_dout;

  assign w_load = (r_state == LOAD);

  neopixel_bit_tx #(
    .TBIT (TBIT),
    .T0H  (T0H),
    .T1H  (T1H)
  ) u_bit_tx (
    .clk         (clk),
    .rst         (rst),
    .i_load      (w_load),
    .i_word      (bus.pix_data),
    .o_dout      (w_dout),
    .o_word_done (w_word_done)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  // Next-state decode
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (bus.frame_req) w_next = FETCH;
      FETCH:   w_next = LOAD;
      LOAD:    w_next = SHIFT;
      SHIFT:   if (w_word_done) w_next = (r_idx == LP_IDX_LAST) ? LATCH : FETCH;
      LATCH:   if (r_lat == LP_LAT_LAST) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Output decode from the upcoming state, registered below
  always_comb begin
    w_rd_d   = (w_next == FETCH);
    w_busy_d = (w_next != IDLE);
    w_done_d = (r_state == LATCH) && (w_next == IDLE);
  end

  // Registered outputs, LED index and latch counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pix_rd <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_idx    <= '0;
      r_lat    <= '0;
    end else begin
      r_pix_rd <= w_rd_d;
      r_busy   <= w_busy_d;
      r_done   <= w_done_d;
      if ((r_state == IDLE) && (w_next == FETCH))       r_idx <= '0;
      else if ((r_state == SHIFT) && (w_next == FETCH)) r_idx <= r_idx + 1'b1;
      if (r_state == LATCH) r_lat <= r_lat + 1'b1;
      else                  r_lat <= '0;
    end
  end

  assign bus.pix_rd     = r_pix_rd;
  assign bus.pix_addr   = r_idx;
  assign bus.busy       = r_busy;
  assign bus.frame_done = r_done;
  assign bus.dout       = w_dout;
endmodule

// File: tb/tb_neopixel_frame_sequencer.sv
// Randomised self-checking bench: reference waveform built from the WS2812 timing rules.
module tb_neopixel_frame_sequencer;
  localparam int TB_TBIT  = 10;
  localparam int TB_T0H   = 3;
  localparam int TB_T1H   = 7;
  localparam int TB_RC    = 20;
  localparam int LED_CYC  = 24 * TB_TBIT + 2;
  localparam int FRAME_L  = 2 * LED_CYC + TB_RC;   // first FETCH .. frame_done inclusive
  localparam int FRAME_L1 = LED_CYC + TB_RC;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  neopixel_frame_sequencer_if #(.NUM_LEDS(2)) bus2 ();
  neopixel_frame_sequencer_if #(.NUM_LEDS(1)) bus1 ();

  neopixel_frame_sequencer #(
    .NUM_LEDS(2), .TBIT(TB_TBIT), .T0H(TB_T0H), .T1H(TB_T1H), .RESET_CYCLES(TB_RC)
  ) u_dut2 (.clk(clk), .rst(rst), .bus(bus2));

  neopixel_frame_sequencer #(
    .NUM_LEDS(1), .TBIT(TB_TBIT), .T0H(TB_T0H), .T1H(TB_T1H), .RESET_CYCLES(TB_RC)
  ) u_dut1 (.clk(clk), .rst(rst), .bus(bus1));

  int unsigned n_cmp  = 0;
  int unsigned n_fail = 0;

  logic [23:0] mem2 [2];
  logic [23:0] mem1;
  logic        prev_rd2 = 1'b0;
  logic        prev_rd1 = 1'b0;

  logic exp_dout [FRAME_L];
  logic exp_rd   [FRAME_L];
  logic exp_addr [FRAME_L];
  logic exp_done [FRAME_L];
  logic act_dout [FRAME_L];

  // Pixel source: answers a read in the following cycle, garbage otherwise
  always @(negedge clk) begin
    if (bus2.pix_rd)    bus2.pix_data = mem2[bus2.pix_addr];
    else if (!prev_rd2) bus2.pix_data = 24'($urandom);
    prev_rd2 = bus2.pix_rd;
    if (bus1.pix_rd)    bus1.pix_data = mem1;
    else if (!prev_rd1) bus1.pix_data = 24'($urandom);
    prev_rd1 = bus1.pix_rd;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, required finish");
    $fatal(1);
  end

  // Expected per-cycle waveform for a 2-LED frame, cycle 0 = first FETCH
  task automatic build_model();
    int pos;
    logic [23:0] w;
    int hi;
    pos = 0;
    for (int i = 0; i < FRAME_L; i++) begin
      exp_dout[i] = 1'b0; exp_rd[i] = 1'b0; exp_addr[i] = 1'b0; exp_done[i] = 1'b0;
    end
    for (int led = 0; led < 2; led++) begin
      exp_rd[pos]   = 1'b1;
      exp_addr[pos] = (led == 1);
      pos += 2;
      w = mem2[led];
      for (int b = 23; b >= 0; b--) begin
        hi = w[b] ? TB_T1H : TB_T0H;
        for (int c = 0; c < TB_TBIT; c++) begin
          exp_dout[pos] = (c < hi);
          pos++;
        end
      end
    end
    exp_done[FRAME_L-1] = 1'b1;
  endtask

  task automatic start_frame(input string tag);
    bus2.frame_req = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (bus2.pix_rd !== 1'b1 || bus2.busy !== 1'b1) begin
      n_fail++;
      $display("FAIL %s start latency: pix_rd=%b busy=%b, required 1 1", tag, bus2.pix_rd, bus2.busy);
    end
  endtask

  // req_mode: 0 drop now, 1 hold, 2 random toggling then low, 3 drop at cycle 100
  task automatic capture_frame(input string tag, input int req_mode);
    int e_dout, e_rd, e_addr, e_done, e_busy, first_bad;
    e_dout = 0; e_rd = 0; e_addr = 0; e_done = 0; e_busy = 0; first_bad = -1;
    for (int i = 0; i < FRAME_L; i++) begin
      act_dout[i] = bus2.dout;
      if (bus2.dout !== exp_dout[i]) begin
        e_dout++;
        if (first_bad < 0) first_bad = i;
      end
      if (bus2.pix_rd !== exp_rd[i]) e_rd++;
      if (exp_rd[i] && bus2.pix_addr !== exp_addr[i]) e_addr++;
      if (bus2.frame_done !== exp_done[i]) e_done++;
      if (bus2.busy !== (i < FRAME_L - 1)) e_busy++;
      case (req_mode)
        0: bus2.frame_req = 1'b0;
        2: bus2.frame_req = (i >= 3 && i + 6 < FRAME_L) ? 1'($urandom % 2) : 1'b0;
        3: if (i == 100) bus2.frame_req = 1'b0;
        default: ;
      endcase
      if (i + 1 < FRAME_L) @(negedge clk);
    end
    n_cmp++;
    if (e_dout != 0) begin
      n_fail++;
      $display("FAIL %s dout: %0d cycles differ (first %0d), required 0", tag, e_dout, first_bad);
    end
    n_cmp++;
    if (e_rd != 0) begin
      n_fail++;
      $display("FAIL %s pix_rd: %0d cycles differ, required 0", tag, e_rd);
    end
    n_cmp++;
    if (e_addr != 0) begin
      n_fail++;
      $display("FAIL %s pix_addr: %0d reads wrong, required 0", tag, e_addr);
    end
    n_cmp++;
    if (e_done != 0) begin
      n_fail++;
      $display("FAIL %s frame_done: %0d cycles differ, required 0", tag, e_done);
    end
    n_cmp++;
    if (e_busy != 0) begin
      n_fail++;
      $display("FAIL %s busy: %0d cycles differ, required 0", tag, e_busy);
    end
  endtask

  task automatic check_idle(input string tag, input int n);
    int hits;
    hits = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (bus2.pix_rd || bus2.busy || bus2.frame_done || bus2.dout) hits++;
    end
    n_cmp++;
    if (hits != 0) begin
      n_fail++;
      $display("FAIL %s idle: %0d active cycles, required 0", tag, hits);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus2.frame_req = 1'b0;
    bus1.frame_req = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({bus2.dout, bus2.busy, bus2.frame_done, bus2.pix_rd, bus2.pix_addr} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset2 outputs: %b, required 00000",
               {bus2.dout, bus2.busy, bus2.frame_done, bus2.pix_rd, bus2.pix_addr});
    end
    n_cmp++;
    if ({bus1.dout, bus1.busy, bus1.frame_done, bus1.pix_rd, bus1.pix_addr} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset1 outputs: %b, required 00000",
               {bus1.dout, bus1.busy, bus1.frame_done, bus1.pix_rd, bus1.pix_addr});
    end
    rst = 1'b0;
    check_idle("post_reset", 4);
  endtask

  task automatic test_frame_basic();
    mem2[0] = 24'h800001;
    mem2[1] = 24'h800001;
    build_model();
    start_frame("basic");
    capture_frame("basic", 0);
  endtask

  task automatic test_random_frames();
    for (int k = 0; k < 3; k++) begin
      mem2[0] = 24'($urandom);
      mem2[1] = 24'($urandom);
      build_model();
      repeat ($urandom_range(1, 5)) @(negedge clk);
      start_frame("random");
      capture_frame("random", 0);
    end
  endtask

  task automatic test_zero_ones();
    int gap;
    mem2[0] = 24'h000000;
    mem2[1] = 24'h000000;
    build_model();
    @(negedge clk);
    start_frame("zeros");
    capture_frame("zeros", 0);
    mem2[0] = 24'hFFFFFF;
    mem2[1] = 24'hFFFFFF;
    build_model();
    @(negedge clk);
    start_frame("ones");
    capture_frame("ones", 0);
    gap = 0;
    for (int k = LED_CYC + 1; k >= 0 && act_dout[k] == 1'b0; k--) gap++;
    n_cmp++;
    if (gap != 5 || act_dout[LED_CYC+2] !== 1'b1) begin
      n_fail++;
      $display("FAIL ones inter-LED gap: %0d low cycles (rise=%b), required 5 (rise=1)",
               gap, act_dout[LED_CYC+2]);
    end
  endtask

  task automatic test_back_to_back();
    mem2[0] = 24'($urandom);
    mem2[1] = 24'($urandom);
    build_model();
    @(negedge clk);
    start_frame("b2b1");
    capture_frame("b2b1", 1);
    @(negedge clk);
    n_cmp++;
    if (bus2.pix_rd !== 1'b1 || bus2.busy !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b restart: pix_rd=%b busy=%b one cycle after frame_done, required 1 1",
               bus2.pix_rd, bus2.busy);
    end
    capture_frame("b2b2", 3);
    check_idle("b2b_end", 30);
  endtask

  task automatic test_ignore_req();
    mem2[0] = 24'($urandom);
    mem2[1] = 24'($urandom);
    build_model();
    start_frame("ignore");
    capture_frame("ignore", 2);
    check_idle("ignore_end", 30);
  endtask

  task automatic test_reset_mid();
    mem2[0] = 24'hFFFFFF;
    mem2[1] = 24'hFFFFFF;
    build_model();
    start_frame("rstmid");
    bus2.frame_req = 1'b0;
    repeat (LED_CYC + 5) @(negedge clk);
    n_cmp++;
    if (bus2.dout !== 1'b1 || bus2.pix_addr !== 1'b1) begin
      n_fail++;
      $display("FAIL rstmid before reset: dout=%b addr=%b, required 1 1", bus2.dout, bus2.pix_addr);
    end
    #1 rst = 1'b1;
    #1;
    n_cmp++;
    if ({bus2.dout, bus2.busy, bus2.pix_rd} !== 3'b000) begin
      n_fail++;
      $display("FAIL rstmid async: dout/busy/pix_rd=%b, required 000", {bus2.dout, bus2.busy, bus2.pix_rd});
    end
    @(negedge clk);
    rst = 1'b0;
    check_idle("rstmid_idle", 3);
    mem2[0] = 24'($urandom);
    mem2[1] = 24'($urandom);
    build_model();
    start_frame("rstmid_new");
    capture_frame("rstmid_new", 0);
  endtask

  task automatic test_single_led();
    int done_at, rds, bad_addr, highs, exp_highs;
    done_at = -1; rds = 0; bad_addr = 0; highs = 0; exp_highs = 0;
    mem1 = 24'($urandom);
    for (int b = 0; b < 24; b++) exp_highs += mem1[b] ? TB_T1H : TB_T0H;
    bus1.frame_req = 1'b1;
    @(negedge clk);
    bus1.frame_req = 1'b0;
    for (int i = 0; i < 400 && done_at < 0; i++) begin
      if (bus1.pix_rd) begin
        rds++;
        if (bus1.pix_addr !== 1'b0) bad_addr++;
      end
      if (bus1.dout === 1'b1) highs++;
      if (bus1.frame_done === 1'b1) done_at = i;
      if (done_at < 0) @(negedge clk);
    end
    n_cmp++;
    if (done_at != FRAME_L1 - 1) begin
      n_fail++;
      $display("FAIL single frame_done: cycle %0d, required %0d", done_at + 1, FRAME_L1);
    end
    n_cmp++;
    if (rds != 1 || bad_addr != 0) begin
      n_fail++;
      $display("FAIL single fetch: %0d reads (%0d bad addr), required 1 (0)", rds, bad_addr);
    end
    n_cmp++;
    if (highs != exp_highs) begin
      n_fail++;
      $display("FAIL single dout high cycles: %0d, required %0d", highs, exp_highs);
    end
  endtask

  initial begin
    test_reset();
    test_frame_basic();
    test_random_frames();
    test_zero_ones();
    test_back_to_back();
    test_ignore_req();
    test_reset_mid();
    test_single_led();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
